// File: rtl/irq_exc_controller.sv
// Interrupt/exception controller at the far end of the core's exception interface.
// Per-source edge detect + pending latch, masked priority select, dispatch FSM
// with a pipeline-depth hold-off window, and a sticky EPC/CAUSE capture.

// One interrupt source: rising-edge detect and pending latch.
module irq_src_lane (
  input  logic clk,
  input  logic reset,
  input  logic src,
  input  logic clr,
  output logic pend,
  output logic pend_nxt
);
  logic prev;

  // Set (new rising edge) wins over a same-cycle clear.
  assign pend_nxt = (pend & ~clr) | (src & ~prev);

  // History resets high so a line already asserted through reset never fires.
  always_ff @(posedge clk) begin
    if (!reset) begin
      prev <= 1'b1;
      pend <= 1'b0;
    end else begin
      prev <= src;
      pend <= pend_nxt;
    end
  end
endmodule

module irq_exc_controller #(
  parameter int N_SRC   = 4,
  parameter int HOLDOFF = 5,
  parameter int CAUSE_W = 4,
  parameter int ID_W    = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_SRC-1:0]   irq_src,
  input  logic [N_SRC-1:0]   irq_mask,
  input  logic               clr_we,
  input  logic [ID_W-1:0]    clr_id,
  input  logic [31:0]        EPC,
  input  logic [CAUSE_W-1:0] CAUSE,
  input  logic               exc_clr,
  output logic               interrupt,
  output logic [ID_W-1:0]    active_id,
  output logic               busy,
  output logic [N_SRC-1:0]   pending,
  output logic               exc_valid,
  output logic [31:0]        exc_epc,
  output logic [CAUSE_W-1:0] exc_cause
);
  localparam int CNT_W = $clog2(HOLDOFF + 1);

  typedef enum logic [1:0] {IDLE, DISPATCH, HOLD, SERVICE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [N_SRC-1:0] clr_vec;
  logic [N_SRC-1:0] pend_nxt;
  logic [N_SRC-1:0] elig;
  logic [ID_W-1:0]  sel;

  // Per-source lanes; clr_id values with no matching lane simply clear nothing.
  for (genvar i = 0; i < N_SRC; i++) begin : g_lane
    assign clr_vec[i] = clr_we && (clr_id == ID_W'(i));
    irq_src_lane u_lane (
      .clk      (clk),
      .reset    (reset),
      .src      (irq_src[i]),
      .clr      (clr_vec[i]),
      .pend     (pending[i]),
      .pend_nxt (pend_nxt[i])
    );
  end

  assign elig = pending & ~irq_mask;

  // Fixed priority: lowest eligible index wins.
  always_comb begin
    sel = '0;
    for (int i = N_SRC - 1; i >= 0; i--)
      if (elig[i]) sel = ID_W'(i);
  end

  // Dispatch FSM. The hold-off counter is loaded on entry to DISPATCH and
  // counts down through DISPATCH and HOLD, so the window after a pulse is
  // exactly HOLDOFF cycles and back-to-back pulses are HOLDOFF+2 apart.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      interrupt <= 1'b0;
      active_id <= '0;
      busy      <= 1'b0;
      cnt       <= '0;
    end else begin
      interrupt <= 1'b0;
      case (state)
        IDLE: begin
          if (|elig && !exc_valid) begin
            state     <= DISPATCH;
            interrupt <= 1'b1;
            active_id <= sel;
            busy      <= 1'b1;
            cnt       <= CNT_W'(HOLDOFF - 1);
          end
        end
        DISPATCH: begin
          if (cnt == '0) state <= SERVICE;
          else begin
            cnt   <= cnt - 1'b1;
            state <= HOLD;
          end
        end
        HOLD: begin
          if (cnt == '0) state <= SERVICE;
          else           cnt   <= cnt - 1'b1;
        end
        SERVICE: begin
          // Uses the post-clear/set value so a clear this cycle ends service now.
          if (!pend_nxt[active_id]) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky exception capture: first report held until exc_clr.
  always_ff @(posedge clk) begin
    if (!reset) begin
      exc_valid <= 1'b0;
      exc_epc   <= '0;
      exc_cause <= '0;
    end else if (CAUSE != '0 && (!exc_valid || exc_clr)) begin
      exc_valid <= 1'b1;
      exc_epc   <= EPC;
      exc_cause <= CAUSE;
    end else if (exc_clr) begin
      exc_valid <= 1'b0;
      exc_epc   <= '0;
      exc_cause <= '0;
    end
  end
endmodule

// File: tb/tb_irq_exc_controller.sv
// Bench for irq_exc_controller: directed steps for the key scenarios followed by
// randomized traffic, all checked each cycle against a cycle-count reference model.
module tb_irq_exc_controller;
  localparam int N = 4;
  localparam int H = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  irq_src = '0;
  logic [3:0]  irq_mask = '0;
  logic        clr_we = 1'b0;
  logic [1:0]  clr_id = '0;
  logic [31:0] EPC = '0;
  logic [3:0]  CAUSE = '0;
  logic        exc_clr = 1'b0;
  logic        interrupt;
  logic [1:0]  active_id;
  logic        busy;
  logic [3:0]  pending;
  logic        exc_valid;
  logic [31:0] exc_epc;
  logic [3:0]  exc_cause;

  irq_exc_controller #(.N_SRC(N), .HOLDOFF(H), .CAUSE_W(4)) dut (
    .clk(clk), .reset(reset), .irq_src(irq_src), .irq_mask(irq_mask),
    .clr_we(clr_we), .clr_id(clr_id), .EPC(EPC), .CAUSE(CAUSE), .exc_clr(exc_clr),
    .interrupt(interrupt), .active_id(active_id), .busy(busy), .pending(pending),
    .exc_valid(exc_valid), .exc_epc(exc_epc), .exc_cause(exc_cause)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: pending bits plus "busy since pulse at cycle m_disp".
  // Service may end once HOLDOFF cycles have passed since the pulse and the
  // active source's pending bit is clear.
  int          cyc = 0;
  int          m_disp = 0;
  logic [3:0]  m_prev = '1, m_pend = '0;
  logic        m_int = 0, m_busy = 0, m_excv = 0;
  logic [1:0]  m_act = '0;
  logic [31:0] m_epc = '0;
  logic [3:0]  m_cause = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic model_step();
    logic [3:0] rise, clrv, np, el;
    if (!reset) begin
      m_prev = '1; m_pend = '0; m_int = 0; m_busy = 0; m_act = '0;
      m_excv = 0; m_epc = '0; m_cause = '0; m_disp = 0;
    end else begin
      rise = irq_src & ~m_prev;
      clrv = clr_we ? (4'b0001 << clr_id) : 4'b0000;
      np   = (m_pend & ~clrv) | rise;
      el   = m_pend & ~irq_mask;
      m_int = 0;
      if (m_busy) begin
        if (cyc >= m_disp + H && !np[m_act]) m_busy = 0;
      end else if (el != 0 && !m_excv) begin
        m_int = 1; m_busy = 1; m_disp = cyc + 1;
        for (int i = N - 1; i >= 0; i--) if (el[i]) m_act = 2'(i);
      end
      if (CAUSE != 0 && (!m_excv || exc_clr)) begin
        m_excv = 1; m_epc = EPC; m_cause = CAUSE;
      end else if (exc_clr) begin
        m_excv = 0; m_epc = '0; m_cause = '0;
      end
      m_prev = irq_src;
      m_pend = np;
    end
    cyc++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("interrupt", interrupt, m_int);
    chk("busy", busy, m_busy);
    chk("pending", pending, m_pend);
    chk("exc_valid", exc_valid, m_excv);
    chk("exc_epc", exc_epc, m_epc);
    chk("exc_cause", exc_cause, m_cause);
    if (m_busy) chk("active_id", active_id, m_act);
  endtask

  task automatic clear_until_idle(input logic [1:0] id);
    clr_we = 1'b1; clr_id = id;
    for (int k = 0; k < 20 && busy; k++) tick();
    clr_we = 1'b0;
    chk("clr_idle", busy, 1'b0);
  endtask

  int  d1, d2;
  bit  got2;

  initial begin
    // 1: reset with a line held high; nothing may fire afterwards
    reset = 1'b0; irq_src = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t1_rst_int", interrupt, 1'b0);
      chk("t1_rst_pend", pending, 4'b0000);
    end
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t1_int", interrupt, 1'b0);
      chk("t1_pend", pending, 4'b0000);
    end
    irq_src = 4'b0000; tick();

    // 2: single source, latency and service end
    irq_src = 4'b0100; tick();
    chk("t2_pend", pending, 4'b0100);
    chk("t2_int_early", interrupt, 1'b0);
    tick();
    chk("t2_int", interrupt, 1'b1);
    chk("t2_act", active_id, 2'd2);
    chk("t2_busy", busy, 1'b1);
    tick();
    chk("t2_int_once", interrupt, 1'b0);
    for (int k = 0; k < 4; k++) tick();
    chk("t2_busy_svc", busy, 1'b1);
    clr_we = 1'b1; clr_id = 2'd2; tick();
    chk("t2_busy_done", busy, 1'b0);
    clr_we = 1'b0; irq_src = 4'b0000; tick();

    // 3: simultaneous rises, priority and pulse spacing
    irq_src = 4'b1010; tick(); tick();
    chk("t3_int1", interrupt, 1'b1);
    chk("t3_act1", active_id, 2'd1);
    d1 = cyc;
    clr_we = 1'b1; clr_id = 2'd1; tick(); clr_we = 1'b0;
    got2 = 0; d2 = 0;
    for (int k = 0; k < 20 && !got2; k++) begin
      tick();
      if (interrupt) begin got2 = 1; d2 = cyc; end
    end
    chk("t3_second", got2, 1'b1);
    chk("t3_act2", active_id, 2'd3);
    chk("t3_spacing", (d2 - d1) >= H + 2, 1'b1);
    clear_until_idle(2'd3);
    irq_src = 4'b0000; tick();

    // 4: masked source stays pending, dispatches once unmasked
    irq_mask = 4'b0010; irq_src = 4'b0010;
    tick(); tick(); tick();
    chk("t4_pend", pending[1], 1'b1);
    chk("t4_noint", interrupt, 1'b0);
    irq_mask = 4'b0000; tick();
    chk("t4_int", interrupt, 1'b1);
    chk("t4_act", active_id, 2'd1);
    clear_until_idle(2'd1);
    irq_src = 4'b0000; tick();

    // 5: exception capture, hold, and dispatch blocking
    CAUSE = 4'h3; EPC = 32'h0000_0040; tick();
    chk("t5_valid", exc_valid, 1'b1);
    chk("t5_epc", exc_epc, 32'h40);
    chk("t5_cause", exc_cause, 4'h3);
    CAUSE = 4'h5; EPC = 32'h0000_0080; tick();
    chk("t5_epc_held", exc_epc, 32'h40);
    chk("t5_cause_held", exc_cause, 4'h3);
    CAUSE = 4'h0; irq_src = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t5_blocked", interrupt, 1'b0);
    end
    chk("t5_pend", pending[0], 1'b1);
    exc_clr = 1'b1; tick(); exc_clr = 1'b0;
    chk("t5_cleared", exc_valid, 1'b0);
    tick();
    chk("t5_int", interrupt, 1'b1);
    chk("t5_act", active_id, 2'd0);

    // 6: set beats clear in the same cycle; reset during HOLD
    irq_src = 4'b0000; tick();
    irq_src = 4'b0001; clr_we = 1'b1; clr_id = 2'd0; tick();
    clr_we = 1'b0;
    chk("t6_set_wins", pending[0], 1'b1);
    reset = 1'b0; tick();
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_int", interrupt, 1'b0);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t6_idle", busy, 1'b0);
    end
    irq_src = 4'b0000; tick();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < N; b++) if ($urandom_range(7) == 0) irq_src[b] = ~irq_src[b];
      if ($urandom_range(15) == 0) irq_mask = ($urandom_range(1) == 0) ? 4'b0000 : 4'($urandom);
      clr_we = ($urandom_range(2) == 0);
      clr_id = (m_busy && $urandom_range(1) == 0) ? m_act : 2'($urandom);
      CAUSE  = ($urandom_range(9) == 0) ? 4'($urandom) : 4'h0;
      EPC    = $urandom;
      exc_clr = ($urandom_range(11) == 0);
      reset  = ($urandom_range(199) != 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
